// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage: drives the instruction-memory address, registers the
// returned word for decode, and handles stall, redirect, end-of-memory halt and misalignment.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        halt_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [1:0]  S_RUN      = 2'd0;
  localparam logic [1:0]  S_HALT     = 2'd1;
  localparam logic [1:0]  S_FAULT    = 2'd2;
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] COUNT_MAX  = 32'hFFFF_FFFF;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        halt_q, halt_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic        redirect_req;
  logic [31:0] target;

  assign redirect_req = jr_i | jump_i | branch_i;

  // Only the highest-priority redirect source forms the target, so only it is alignment-checked.
  always_comb begin
    if (jr_i)        target = jr_target_i;
    else if (jump_i) target = {pc_plus4_q[31:28], jump_index_i, 2'b00};
    else             target = pc_plus4_q + (branch_offset_i << 2);
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    fetch_pc_d = fetch_pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    misalign_d = misalign_q;
    count_d    = count_q;

    if (state_q == S_RUN && !stall_i) begin
      if (valid_q && redirect_req) begin
        if (target[1:0] != 2'b00) begin
          state_d    = S_FAULT;
          misalign_d = 1'b1;
          valid_d    = 1'b0;
        end else begin
          pc_d    = target;
          instr_d = '0;
          valid_d = 1'b0;
        end
      end else if (pc_q >= IMEM_BYTES) begin
        state_d = S_HALT;
        halt_d  = 1'b1;
        valid_d = 1'b0;
      end else begin
        instr_d    = imem_instr_i;
        fetch_pc_d = pc_q;
        pc_plus4_d = pc_q + 32'd4;
        valid_d    = 1'b1;
        pc_d       = pc_q + 32'd4;
        count_d    = (count_q == COUNT_MAX) ? count_q : count_q + 32'd1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous here, so it is just the highest-priority branch of the edge-triggered block.
    if (rst_i) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      fetch_pc_q <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      fetch_pc_q <= fetch_pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = fetch_pc_q;
  assign pc_plus4_o    = pc_plus4_q;
  assign valid_o       = valid_q;
  assign halt_o        = halt_q;
  assign misalign_o    = misalign_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a cycle-level reference model queues expected outputs,
// an independent monitor pops and compares them after every rising edge.
module tb_pc_fetch_unit;

  localparam int          W     = 8;
  localparam int          AW    = $clog2(W);
  localparam logic [31:0] BYTES = 32'(W * 4);

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, stall_i = 1'b0, branch_i = 1'b0, jump_i = 1'b0, jr_i = 1'b0;
  logic [31:0] branch_offset_i = '0, jr_target_i = '0;
  logic [25:0] jump_index_i = '0;
  logic [31:0] imem_addr_o, imem_instr_i, instr_o, pc_o, pc_plus4_o, fetch_count_o;
  logic        valid_o, halt_o, misalign_o;

  logic [31:0] mem [W];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_offset_i(branch_offset_i),
    .jump_i(jump_i), .jump_index_i(jump_index_i),
    .jr_i(jr_i), .jr_target_i(jr_target_i),
    .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .valid_o(valid_o), .halt_o(halt_o), .misalign_o(misalign_o),
    .fetch_count_o(fetch_count_o)
  );

  // Instruction memory: combinational read, recognisable filler outside the array.
  always_comb begin
    imem_instr_i = 32'hDEAD_BEEF;
    if (imem_addr_o < BYTES) imem_instr_i = mem[imem_addr_o[AW+1:2]];
  end

  // ---------------- reference model ----------------
  typedef enum int {M_RUN, M_HALT, M_FAULT} mstate_t;
  typedef struct {
    logic [31:0] addr, instr, pc, pcp4, cnt;
    logic        valid, halt, mis;
  } exp_t;

  mstate_t     m_state;
  logic [31:0] m_pc, m_instr, m_pco, m_pcp4, m_cnt;
  logic        m_valid, m_halt, m_mis;
  exp_t        sb_q [$];

  task automatic model_step();
    logic [31:0] tgt;
    if (rst_i) begin
      m_state = M_RUN; m_pc = 0; m_instr = 0; m_pco = 0; m_pcp4 = 0;
      m_valid = 0; m_halt = 0; m_mis = 0; m_cnt = 0;
    end else if (m_state == M_RUN && !stall_i) begin
      if (m_valid && (jr_i || jump_i || branch_i)) begin
        if (jr_i)        tgt = jr_target_i;
        else if (jump_i) tgt = (m_pcp4 & 32'hF000_0000) | (32'(jump_index_i) * 32'd4);
        else             tgt = m_pcp4 + branch_offset_i * 32'd4;
        if (tgt % 4 != 0) begin
          m_state = M_FAULT; m_mis = 1; m_valid = 0;
        end else begin
          m_pc = tgt; m_instr = 0; m_valid = 0;
        end
      end else if (m_pc >= BYTES) begin
        m_state = M_HALT; m_halt = 1; m_valid = 0;
      end else begin
        m_instr = mem[m_pc[AW+1:2]];
        m_pco   = m_pc;
        m_pcp4  = m_pc + 4;
        m_pc    = m_pc + 4;
        m_valid = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
    sb_q.push_back('{addr: m_pc, instr: m_instr, pc: m_pco, pcp4: m_pcp4, cnt: m_cnt,
                     valid: m_valid, halt: m_halt, mis: m_mis});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("imem_addr", imem_addr_o, e.addr);
        check("instr", instr_o, e.instr);
        check("pc", pc_o, e.pc);
        check("pc_plus4", pc_plus4_o, e.pcp4);
        check("count", fetch_count_o, e.cnt);
        check("valid", 32'(valid_o), 32'(e.valid));
        check("halt", 32'(halt_o), 32'(e.halt));
        check("misalign", 32'(misalign_o), 32'(e.mis));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic rst, input logic stall, input logic br, input logic [31:0] off,
                      input logic j, input logic [25:0] idx, input logic jr, input logic [31:0] jt);
    @(negedge clk);
    rst_i = rst; stall_i = stall; branch_i = br; branch_offset_i = off;
    jump_i = j; jump_index_i = idx; jr_i = jr; jr_target_i = jt;
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic t_seq();   tick(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_rst();   tick(1, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < W; i++) mem[i] = $urandom();

    // Sequential fetch from reset.
    t_rst();
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    repeat (3) t_seq();
    check("seq_count", fetch_count_o, 32'd3);
    check("seq_pc", pc_o, 32'd8);
    check("seq_instr", instr_o, mem[2]);
    check("seq_addr", imem_addr_o, 32'd12);

    // Backward branch: 12 + (-2 << 2) = 4, one bubble.
    tick(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    check("br_addr", imem_addr_o, 32'd4);
    check("br_bubble_valid", 32'(valid_o), 32'd0);
    check("br_bubble_instr", instr_o, 32'd0);
    check("br_bubble_count", fetch_count_o, 32'd3);
    t_seq();
    check("br_instr", instr_o, mem[1]);
    check("br_pc", pc_o, 32'd4);
    check("br_count", fetch_count_o, 32'd4);

    // jr beats jump.
    tick(0, 0, 0, 0, 1, 26'h5, 1, 32'h18);
    check("jr_win_addr", imem_addr_o, 32'h18);

    // Misaligned jr target faults; fault absorbs stall toggling.
    t_rst();
    t_seq();
    tick(0, 0, 0, 0, 0, 0, 1, 32'h1A);
    check("fault_mis", 32'(misalign_o), 32'd1);
    check("fault_valid", 32'(valid_o), 32'd0);
    for (int i = 0; i < 5; i++) tick(0, logic'(i % 2), 0, 0, 1, 26'h3, 0, 0);
    check("fault_hold_addr", imem_addr_o, 32'd4);
    check("fault_hold_mis", 32'(misalign_o), 32'd1);

    // Stall with a redirect pulse mid-stall.
    t_rst();
    repeat (3) t_seq();
    tick(0, 1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 32'h4, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0);
    check("stall_addr", imem_addr_o, 32'd12);
    check("stall_pc", pc_o, 32'd8);
    check("stall_count", fetch_count_o, 32'd3);
    t_seq();
    check("stall_resume_pc", pc_o, 32'd12);

    // Run off the end of memory.
    repeat (W - 4) t_seq();
    t_seq();
    check("halt_flag", 32'(halt_o), 32'd1);
    check("halt_valid", 32'(valid_o), 32'd0);
    check("halt_pc", pc_o, BYTES - 4);
    check("halt_instr", instr_o, mem[W-1]);
    check("halt_count", fetch_count_o, 32'(W));
    repeat (2) tick(0, 0, 1, 32'hFFFF_FFF0, 0, 0, 0, 0);
    check("halt_hold_addr", imem_addr_o, BYTES);

    // Reset out of HALT, then reset during a stall.
    t_rst();
    check("rst_halt_flag", 32'(halt_o), 32'd0);
    check("rst_halt_count", fetch_count_o, 32'd0);
    repeat (2) t_seq();
    tick(1, 1, 0, 0, 0, 0, 0, 0);
    check("rst_stall_addr", imem_addr_o, 32'd0);
    check("rst_stall_count", fetch_count_o, 32'd0);

    // Randomised traffic.
    for (int c = 0; c < 800; c++) begin
      logic        r, s, b, j, jr;
      logic [31:0] off, jt;
      logic [25:0] idx;
      r   = ($urandom_range(0, 79) == 0) || (m_state != M_RUN && $urandom_range(0, 9) == 0);
      s   = ($urandom_range(0, 4) == 0);
      b   = ($urandom_range(0, 5) == 0);
      off = 32'($urandom_range(0, 15)) - 32'd8;
      j   = ($urandom_range(0, 7) == 0);
      idx = 26'($urandom_range(0, 9));
      jr  = ($urandom_range(0, 9) == 0);
      jt  = 32'($urandom_range(0, 11)) * 32'd4;
      if ($urandom_range(0, 7) == 0) jt = jt + 32'($urandom_range(1, 3));
      tick(r, s, b, off, j, idx, jr, jt);
    end

    repeat (2) @(posedge clk);
    #2;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch stage sitting directly upstream of the instruction memory. It owns the PC register, drives the instruction-memory address, and captures the returned word into a registered fetch output for the decoder. It accepts branch, jump and jump-register redirects from later stages. It also supports stalls, halts at the end of instruction memory, and flags misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
IMEM_WORDS, 32, number of 32-bit words in instruction memory; fetch address range is 0..4*IMEM_WORDS-1

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
stall_i  input  1  hold all fetch state this cycle
branch_i  input  1  taken-branch redirect for the instruction in instr_o
branch_offset_i  input  32  sign-extended word offset (pre-shift)
jump_i  input  1  j/jal redirect
jump_index_i  input  26  instr[25:0] of jump
jr_i  input  1  jump-register redirect
jr_target_i  input  32  byte address from register file
imem_addr_o  output  32  byte address to instruction memory (= pc_q, combinational)
imem_instr_i  input  32  word returned combinationally by instruction memory
instr_o  output  32  registered fetched instruction
pc_o  output  32  PC of instr_o
pc_plus4_o  output  32  pc_o + 4
valid_o  output  1  instr_o holds a live instruction
halt_o  output  1  fetch stopped, end of memory reached
misalign_o  output  1  sticky: redirect target not word aligned
fetch_count_o  output  32  count of valid instructions delivered, saturating

Behaviour:
- State machine: RUN, HALT, FAULT. Reset values: state=RUN, pc_q=RESET_PC, instr_o=0, pc_o=0, pc_plus4_o=0, valid_o=0, halt_o=0, misalign_o=0, fetch_count_o=0.
- rst_i takes priority over every other input and every state. It restores the reset values on the next edge, including mid-stall, HALT and FAULT.
- imem_addr_o = pc_q at all times. No memory latency is assumed; the word is sampled on the same edge.
- Priority order in RUN: stall, then redirect, then sequential.
  - Stall: stall_i=1 holds pc_q, instr_o, pc_o, pc_plus4_o, valid_o and the count. Redirect inputs are ignored; the source holds them until the stall drops.
  - Redirect: applies only when valid_o=1 and at least one of jr_i, jump_i, branch_i is 1. Precedence is jr_i, then jump_i, then branch_i.
  - Redirect targets:
    - jr: jr_target_i.
    - jump: {pc_plus4_o[31:28], jump_index_i, 2'b00}.
    - branch: pc_plus4_o + (branch_offset_i << 2), 32-bit wrap-around.
  - Redirect effect: pc_q <= target. The word fetched this cycle is squashed: instr_o <= 0, valid_o <= 0. pc_o and pc_plus4_o hold. The count does not increment. This gives exactly one bubble cycle.
  - Redirect while valid_o=0: ignored.
  - Sequential: instr_o <= imem_instr_i, pc_o <= pc_q, pc_plus4_o <= pc_q+4, valid_o <= 1, pc_q <= pc_q+4, fetch_count_o <= fetch_count_o+1 (holds at 32'hFFFF_FFFF).
- Misaligned redirect target (target[1:0] != 0): state goes to FAULT, misalign_o <= 1, valid_o <= 0, pc_q unchanged.
- End of memory: evaluated in RUN with stall_i=0 and no redirect. If pc_q >= 4*IMEM_WORDS:
  - no fetch;
  - state goes to HALT, halt_o <= 1, valid_o <= 0;
  - the last valid instruction remains in instr_o/pc_o;
  - pc_q is frozen.
- A redirect to an out-of-range aligned target is accepted. The halt then triggers on the following cycle.
- HALT and FAULT are absorbing until reset. All inputs except rst_i are ignored. Outputs hold, with valid_o=0.
- Simultaneous branch_i, jump_i and jr_i: only the highest-priority one is used. Only that target is checked for alignment.

Test Plan:
1. Reset, memory words 0..3 = A,B,C,D, no redirects → imem_addr_o 0,4,8,12. instr_o A,B,C on cycles 1..3 with pc_o 0,4,8. valid_o goes 1 from cycle 1. fetch_count_o=3 after 3 cycles.
2. With instr_o at pc_o=8, assert branch_i with offset 32'hFFFF_FFFE → next pc_q=4. One cycle valid_o=0 with instr_o=0, then instr_o=word1 with pc_o=4. Count increments by 1 only after the bubble.
3. jump_i with jump_index_i=26'h5 and jr_i with jr_target_i=0x18 asserted together → jr wins, imem_addr_o=0x18. In a separate run, jr_target_i=0x1A → misalign_o=1 and valid_o=0. FAULT persists for 5 cycles with stall_i toggling.
4. stall_i=1 for 3 cycles mid-run → imem_addr_o, instr_o, pc_o and count frozen. Redirect pulsed during the stall is ignored. Sequential flow resumes on release.
5. IMEM_WORDS=4, run from 0 → valid fetches at 0,4,8,12. On pc_q=16, halt_o=1 and valid_o=0. instr_o stays at word 3 with pc_o=12. fetch_count_o=4.
6. rst_i asserted during HALT, and separately during a stall → next edge gives pc_q=RESET_PC, halt_o=0, misalign_o=0, count=0, state RUN.
